// File: rtl/decode_unit.sv
// decode_unit: three-stage decoder for a PowerPC-style subset (D, B and A forms).
// Stage 1 registers the instruction, stage 2 classifies it, stage 3 formats the
// output bundle. IBM bit numbering: instruction bit k is instruction_i[31-k],
// body bit k is bodyOut[83-k], so the 64-bit immediate sits in bodyOut[63:0].
// Optional macro DECODE_UNIT_TRACE_EN: prints each valid output (simulation only).
module decode_unit #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int opcodeSize              = 12,
    parameter int regAccessPatternSize    = 2,
    parameter int funcUnitCodeSize        = 3
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic                               stall_i,
    input  logic [instructionWidth-1:0]        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    input  logic [instructionCounterWidth-1:0] instructionMajId_i,
    output logic                               enableOut,
    output logic [24:0]                        instFormat_o,
    output logic [opcodeSize-1:0]              opcodeOut,
    output logic [addressWidth-1:0]            addressOut,
    output logic                               is64BitOut,
    output logic [PidSize-1:0]                 pidOut,
    output logic [TidSize-1:0]                 tidOut,
    output logic [instructionCounterWidth-1:0] majIDOut,
    output logic [instMinIdWidth-1:0]          minIDOut,
    output logic [funcUnitCodeSize-1:0]        funcUnitTypeOut,
    output logic [regAccessPatternSize-1:0]    op1rwOut,
    output logic [regAccessPatternSize-1:0]    op2rwOut,
    output logic [regAccessPatternSize-1:0]    op3rwOut,
    output logic [regAccessPatternSize-1:0]    op4rwOut,
    output logic                               op1IsRegOut,
    output logic                               op2IsRegOut,
    output logic                               op3IsRegOut,
    output logic                               op4IsRegOut,
    output logic [83:0]                        bodyOut
);

    localparam logic [1:0] KIND_D = 2'd0;
    localparam logic [1:0] KIND_B = 2'd1;
    localparam logic [1:0] KIND_A = 2'd2;

    localparam logic [24:0] FMT_B = 25'd2;
    localparam logic [24:0] FMT_D = 25'd32;
    localparam logic [24:0] FMT_A = 25'd512;

    localparam logic [funcUnitCodeSize-1:0] UNIT_INT = 'd0;
    localparam logic [funcUnitCodeSize-1:0] UNIT_LS  = 'd1;
    localparam logic [funcUnitCodeSize-1:0] UNIT_BR  = 'd2;
    localparam logic [funcUnitCodeSize-1:0] UNIT_FP  = 'd3;

    localparam logic [regAccessPatternSize-1:0] ACC_R = 'd1;
    localparam logic [regAccessPatternSize-1:0] ACC_W = 'd2;

    // ---------------- stage 1 ----------------
    logic                               r1_valid;
    logic [instructionWidth-1:0]        r1_instr;
    logic [addressWidth-1:0]            r1_addr;
    logic                               r1_is64;
    logic [PidSize-1:0]                 r1_pid;
    logic [TidSize-1:0]                 r1_tid;
    logic [instructionCounterWidth-1:0] r1_maj;

    // Capture the incoming instruction and its sideband unless stalled
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r1_valid <= 1'b0;
            r1_instr <= '0;
            r1_addr  <= '0;
            r1_is64  <= 1'b0;
            r1_pid   <= '0;
            r1_tid   <= '0;
            r1_maj   <= '0;
        end else if (!stall_i) begin
            r1_valid <= enable_i;
            r1_instr <= instruction_i;
            r1_addr  <= instructionAddress_i;
            r1_is64  <= is64Bit_i;
            r1_pid   <= instructionPid_i;
            r1_tid   <= instructionTid_i;
            r1_maj   <= instructionMajId_i;
        end
    end

    // ---------------- stage 2 ----------------
    logic [5:0] w_primary;
    logic [4:0] w_xop;
    assign w_primary = r1_instr[31:26];
    assign w_xop     = r1_instr[5:1];

    logic w_is_d, w_is_b, w_is_a, w_xop_fp, w_op1_read, w_zext;

    // Match the stage-1 instruction against the supported encodings
    always_comb begin
        w_xop_fp   = w_xop inside {5'd18, 5'd20, 5'd21, 5'd22, 5'd24, 5'd25,
                                   5'd26, 5'd28, 5'd29, 5'd30, 5'd31};
        w_is_d     = w_primary inside {6'd2, 6'd3, 6'd7, 6'd8, [6'd10:6'd15],
                                       [6'd24:6'd29], [6'd32:6'd55]};
        w_is_b     = (w_primary == 6'd16);
        w_is_a     = ((w_primary == 6'd59) && w_xop_fp) ||
                     ((w_primary == 6'd63) && (w_xop_fp || (w_xop == 5'd23))) ||
                     ((w_primary == 6'd31) && (w_xop == 5'd15));
        // traps, compares and stores only read their first register
        w_op1_read = w_primary inside {6'd2, 6'd3, 6'd10, 6'd11, [6'd36:6'd39],
                                       6'd44, 6'd45, 6'd47, [6'd52:6'd55]};
        // logical immediates are unsigned
        w_zext     = w_primary inside {[6'd24:6'd29]};
    end

    logic [1:0]                  w_kind;
    logic [funcUnitCodeSize-1:0] w_unit;
    logic                        w_supported;

    // Pick the instruction form and functional unit
    always_comb begin
        w_supported = 1'b1;
        w_kind      = KIND_D;
        w_unit      = UNIT_INT;
        if (w_is_d) begin
            w_kind = KIND_D;
            w_unit = w_primary[5] ? UNIT_LS : UNIT_INT;
        end else if (w_is_b) begin
            w_kind = KIND_B;
            w_unit = UNIT_BR;
        end else if (w_is_a) begin
            w_kind = KIND_A;
            w_unit = (w_primary == 6'd31) ? UNIT_INT : UNIT_FP;
        end else begin
            w_supported = 1'b0;
        end
    end

    logic                               r2_valid;
    logic [1:0]                         r2_kind;
    logic [funcUnitCodeSize-1:0]        r2_unit;
    logic                               r2_op1_read;
    logic                               r2_zext;
    logic [instructionWidth-1:0]        r2_instr;
    logic [addressWidth-1:0]            r2_addr;
    logic                               r2_is64;
    logic [PidSize-1:0]                 r2_pid;
    logic [TidSize-1:0]                 r2_tid;
    logic [instructionCounterWidth-1:0] r2_maj;

    // Register the classification; unsupported encodings become bubbles here
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r2_valid    <= 1'b0;
            r2_kind     <= KIND_D;
            r2_unit     <= UNIT_INT;
            r2_op1_read <= 1'b0;
            r2_zext     <= 1'b0;
            r2_instr    <= '0;
            r2_addr     <= '0;
            r2_is64     <= 1'b0;
            r2_pid      <= '0;
            r2_tid      <= '0;
            r2_maj      <= '0;
        end else if (!stall_i) begin
            r2_valid    <= r1_valid && w_supported;
            r2_kind     <= w_kind;
            r2_unit     <= w_unit;
            r2_op1_read <= w_op1_read;
            r2_zext     <= w_zext;
            r2_instr    <= r1_instr;
            r2_addr     <= r1_addr;
            r2_is64     <= r1_is64;
            r2_pid      <= r1_pid;
            r2_tid      <= r1_tid;
            r2_maj      <= r1_maj;
        end
    end

    // ---------------- stage 3 ----------------
    logic                            w_en;
    logic [24:0]                     w_fmt;
    logic [opcodeSize-1:0]           w_opc;
    logic [funcUnitCodeSize-1:0]     w_unit_o;
    logic [regAccessPatternSize-1:0] w_rw1, w_rw2, w_rw3, w_rw4;
    logic                            w_reg1, w_reg2, w_reg3, w_reg4;
    logic [83:0]                     w_body;

    // Build the output bundle; branch fields are CR/immediate, not GPR operands
    always_comb begin
        w_en     = 1'b0;
        w_fmt    = '0;
        w_opc    = '0;
        w_unit_o = '0;
        w_rw1    = '0;
        w_rw2    = '0;
        w_rw3    = '0;
        w_rw4    = '0;
        w_reg1   = 1'b0;
        w_reg2   = 1'b0;
        w_reg3   = 1'b0;
        w_reg4   = 1'b0;
        w_body   = '0;
        if (r2_valid) begin
            w_en           = 1'b1;
            w_unit_o       = r2_unit;
            w_body[83:79]  = r2_instr[25:21];
            w_body[78:74]  = r2_instr[20:16];
            case (r2_kind)
                KIND_D: begin
                    w_fmt         = FMT_D;
                    w_opc         = {r2_instr[31:26], 6'b0};
                    w_body[63:0]  = r2_zext ? {48'b0, r2_instr[15:0]}
                                            : {{48{r2_instr[15]}}, r2_instr[15:0]};
                    w_rw1         = r2_op1_read ? ACC_R : ACC_W;
                    w_reg1        = 1'b1;
                    w_rw2         = ACC_R;
                    w_reg2        = 1'b1;
                    w_rw3         = ACC_R;
                end
                KIND_B: begin
                    w_fmt         = FMT_B;
                    w_opc         = {r2_instr[31:26], 6'b0};
                    w_body[73]    = r2_instr[1];
                    w_body[72]    = r2_instr[0];
                    w_body[63:0]  = {{48{r2_instr[15]}}, r2_instr[15:2], 2'b00};
                end
                default: begin
                    w_fmt         = FMT_A;
                    w_opc         = {r2_instr[31:26], 1'b0, r2_instr[5:1]};
                    w_body[73:69] = r2_instr[15:11];
                    w_body[68:64] = r2_instr[10:6];
                    w_body[63]    = r2_instr[0];
                    w_rw1         = ACC_W;
                    w_reg1        = 1'b1;
                    w_rw2         = ACC_R;
                    w_reg2        = 1'b1;
                    w_rw3         = ACC_R;
                    w_reg3        = 1'b1;
                    w_rw4         = ACC_R;
                    // isel's fourth operand is a CR bit index
                    w_reg4        = (r2_instr[31:26] != 6'd31);
                end
            endcase
        end
    end

    // Output register; bubbles drive every field to zero
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            enableOut       <= 1'b0;
            instFormat_o    <= '0;
            opcodeOut       <= '0;
            addressOut      <= '0;
            is64BitOut      <= 1'b0;
            pidOut          <= '0;
            tidOut          <= '0;
            majIDOut        <= '0;
            funcUnitTypeOut <= '0;
            op1rwOut        <= '0;
            op2rwOut        <= '0;
            op3rwOut        <= '0;
            op4rwOut        <= '0;
            op1IsRegOut     <= 1'b0;
            op2IsRegOut     <= 1'b0;
            op3IsRegOut     <= 1'b0;
            op4IsRegOut     <= 1'b0;
            bodyOut         <= '0;
        end else if (!stall_i) begin
            enableOut       <= w_en;
            instFormat_o    <= w_fmt;
            opcodeOut       <= w_opc;
            addressOut      <= r2_valid ? r2_addr : '0;
            is64BitOut      <= r2_valid && r2_is64;
            pidOut          <= r2_valid ? r2_pid : '0;
            tidOut          <= r2_valid ? r2_tid : '0;
            majIDOut        <= r2_valid ? r2_maj : '0;
            funcUnitTypeOut <= w_unit_o;
            op1rwOut        <= w_rw1;
            op2rwOut        <= w_rw2;
            op3rwOut        <= w_rw3;
            op4rwOut        <= w_rw4;
            op1IsRegOut     <= w_reg1;
            op2IsRegOut     <= w_reg2;
            op3IsRegOut     <= w_reg3;
            op4IsRegOut     <= w_reg4;
            bodyOut         <= w_body;
        end
    end

    assign minIDOut = '0;

`ifdef DECODE_UNIT_TRACE_EN
    // Simulation trace of every valid output bundle
    always @(posedge clock_i) begin
        if (enableOut)
            $display("decode_unit: maj=%0d addr=%h fmt=%0d opc=%h",
                     majIDOut, addressOut, instFormat_o, opcodeOut);
    end
`else
    // trace disabled: no print logic
`endif

endmodule

// File: tb/tb_decode_unit.sv
`timescale 1ns/1ps
module tb_decode_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i, enable_i, stall_i, is64_i;
    logic [31:0] instruction_i;
    logic [63:0] addr_i, maj_i;
    logic [19:0] pid_i;
    logic [15:0] tid_i;

    logic        enableOut, is64BitOut;
    logic [24:0] instFormat_o;
    logic [11:0] opcodeOut;
    logic [63:0] addressOut, majIDOut;
    logic [19:0] pidOut;
    logic [15:0] tidOut;
    logic [6:0]  minIDOut;
    logic [2:0]  funcUnitTypeOut;
    logic [1:0]  op1rwOut, op2rwOut, op3rwOut, op4rwOut;
    logic        op1IsRegOut, op2IsRegOut, op3IsRegOut, op4IsRegOut;
    logic [83:0] bodyOut;

    decode_unit dut (
        .clock_i(clk), .reset_i(reset_i), .enable_i(enable_i), .stall_i(stall_i),
        .instruction_i(instruction_i), .instructionAddress_i(addr_i),
        .is64Bit_i(is64_i), .instructionPid_i(pid_i), .instructionTid_i(tid_i),
        .instructionMajId_i(maj_i),
        .enableOut(enableOut), .instFormat_o(instFormat_o), .opcodeOut(opcodeOut),
        .addressOut(addressOut), .is64BitOut(is64BitOut), .pidOut(pidOut),
        .tidOut(tidOut), .majIDOut(majIDOut), .minIDOut(minIDOut),
        .funcUnitTypeOut(funcUnitTypeOut),
        .op1rwOut(op1rwOut), .op2rwOut(op2rwOut), .op3rwOut(op3rwOut), .op4rwOut(op4rwOut),
        .op1IsRegOut(op1IsRegOut), .op2IsRegOut(op2IsRegOut),
        .op3IsRegOut(op3IsRegOut), .op4IsRegOut(op4IsRegOut),
        .bodyOut(bodyOut)
    );

    typedef struct packed {
        logic        en;
        logic [24:0] fmt;
        logic [11:0] opc;
        logic [63:0] addr;
        logic        is64;
        logic [19:0] pid;
        logic [15:0] tid;
        logic [63:0] maj;
        logic [6:0]  minid;
        logic [2:0]  unit;
        logic [1:0]  rw1, rw2, rw3, rw4;
        logic        r1, r2, r3, r4;
        logic [83:0] body;
    } bundle_t;

    bundle_t got, exp_out, h1, h2;
    assign got = {enableOut, instFormat_o, opcodeOut, addressOut, is64BitOut, pidOut,
                  tidOut, majIDOut, minIDOut, funcUnitTypeOut,
                  op1rwOut, op2rwOut, op3rwOut, op4rwOut,
                  op1IsRegOut, op2IsRegOut, op3IsRegOut, op4IsRegOut, bodyOut};

    int n_vec = 0;
    int n_err = 0;

    // IBM-numbered field extraction: bits pos..pos+len-1, bit 0 = MSB
    function automatic logic [63:0] fld(input logic [31:0] ins, input int pos, input int len);
        logic [31:0] t;
        t = ins >> (32 - pos - len);
        return {32'b0, t & ((32'd1 << len) - 32'd1)};
    endfunction

    // Place a value into the 84-bit body at IBM position pos
    function automatic logic [83:0] put(input logic [83:0] body, input logic [63:0] v,
                                        input int pos, input int len);
        logic [83:0] m;
        m = (len >= 64) ? {20'b0, {64{1'b1}}} : ((84'd1 << len) - 84'd1);
        return body | (({20'b0, v} & m) << (84 - pos - len));
    endfunction

    function automatic bundle_t model(input logic [31:0] ins, input logic [63:0] addr,
                                      input logic is64, input logic [19:0] pid,
                                      input logic [15:0] tid, input logic [63:0] maj);
        bundle_t b;
        int p, x;
        bit is_d, is_b, is_a, rd1;
        logic [63:0] v;
        int fpx[11]  = '{18, 20, 21, 22, 24, 25, 26, 28, 29, 30, 31};
        int dops[9]  = '{2, 3, 7, 8, 10, 11, 12, 13, 14};
        int rdops[15] = '{2, 3, 10, 11, 36, 37, 38, 39, 44, 45, 47, 52, 53, 54, 55};
        b = '0;
        p = int'(fld(ins, 0, 6));
        x = int'(fld(ins, 26, 5));
        is_d = (p == 15) || (p >= 24 && p <= 29) || (p >= 32 && p <= 55);
        foreach (dops[i]) if (dops[i] == p) is_d = 1;
        is_b = (p == 16);
        is_a = (p == 31 && x == 15) || (p == 63 && x == 23);
        if (p == 59 || p == 63) foreach (fpx[i]) if (fpx[i] == x) is_a = 1;
        if (!(is_d || is_b || is_a)) return b;
        b.en = 1; b.addr = addr; b.is64 = is64; b.pid = pid; b.tid = tid; b.maj = maj;
        b.body = put(b.body, fld(ins, 6, 5), 0, 5);
        b.body = put(b.body, fld(ins, 11, 5), 5, 5);
        if (is_d) begin
            rd1 = 0;
            foreach (rdops[i]) if (rdops[i] == p) rd1 = 1;
            b.fmt = 25'd32; b.opc = 12'(p * 64); b.unit = (p >= 32) ? 3'd1 : 3'd0;
            v = fld(ins, 16, 16);
            if (!(p >= 24 && p <= 29) && v >= 64'd32768) v = v - 64'd65536;
            b.body = put(b.body, v, 20, 64);
            b.rw1 = rd1 ? 2'd1 : 2'd2; b.r1 = 1;
            b.rw2 = 2'd1; b.r2 = 1;
            b.rw3 = 2'd1;
        end else if (is_b) begin
            b.fmt = 25'd2; b.opc = 12'(p * 64); b.unit = 3'd2;
            b.body = put(b.body, fld(ins, 30, 1), 10, 1);
            b.body = put(b.body, fld(ins, 31, 1), 11, 1);
            v = fld(ins, 16, 14) * 4;
            if (v >= 64'd32768) v = v - 64'd65536;
            b.body = put(b.body, v, 20, 64);
        end else begin
            b.fmt = 25'd512; b.opc = 12'(p * 64 + x); b.unit = (p == 31) ? 3'd0 : 3'd3;
            b.body = put(b.body, fld(ins, 16, 5), 10, 5);
            b.body = put(b.body, fld(ins, 21, 5), 15, 5);
            b.body = put(b.body, fld(ins, 31, 1), 20, 1);
            b.rw1 = 2'd2; b.r1 = 1;
            b.rw2 = 2'd1; b.r2 = 1;
            b.rw3 = 2'd1; b.r3 = 1;
            b.rw4 = 2'd1; b.r4 = (p != 31);
        end
        return b;
    endfunction

    // One clock: drive at negedge, advance the 3-deep reference delay line
    task automatic cycle(input logic en, input logic st, input logic [31:0] ins,
                         input logic [63:0] maj);
        @(negedge clk);
        enable_i = en; stall_i = st; instruction_i = ins; maj_i = maj;
        addr_i = {$urandom, $urandom}; is64_i = 1'($urandom);
        pid_i = 20'($urandom); tid_i = 16'($urandom);
        @(posedge clk);
        if (!st) begin
            exp_out = h2;
            h2 = h1;
            h1 = en ? model(ins, addr_i, is64_i, pid_i, tid_i, maj) : '0;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int sel;
        r = $urandom;
        sel = $urandom_range(0, 3);
        if (sel == 1) begin
            case ($urandom_range(0, 2))
                0: r[31:26] = 6'd59;
                1: r[31:26] = 6'd63;
                default: r[31:26] = 6'd31;
            endcase
        end else if (sel == 2) begin
            r[31:26] = 6'($urandom_range(0, 63));
        end else if (sel == 3) begin
            r[31:26] = 6'd16;
        end
        return r;
    endfunction

    task automatic test_reset();
        reset_i = 1'b0; enable_i = 1'b1; stall_i = 1'b0; instruction_i = 32'hFC1F_F82A;
        addr_i = 64'h1234; is64_i = 1'b1; pid_i = 20'h5; tid_i = 16'h6; maj_i = 64'h7;
        h1 = '0; h2 = '0; exp_out = '0;
        repeat (3) begin
            @(posedge clk); #1;
            n_vec++;
            if (got !== '0) begin
                n_err++;
                $display("FAIL reset_hold: got %h expected 0", got);
            end
        end
        @(negedge clk);
        reset_i = 1'b1; enable_i = 1'b0;
    endtask

    task automatic test_latency();
        int first;
        logic [24:0] fmt_seen;
        first = -1; fmt_seen = '0;
        for (int c = 1; c <= 6; c++) begin
            cycle(c == 1, 1'b0, (c == 1) ? 32'hFC1F_F82A : $urandom, 64'(c));
            n_vec++;
            if (got !== exp_out) begin
                n_err++;
                $display("FAIL latency_c%0d: got %h expected %h", c, got, exp_out);
            end
            if (got.en === 1'b1 && first < 0) begin
                first = c; fmt_seen = got.fmt;
            end
        end
        n_vec++;
        if (first != 3) begin
            n_err++;
            $display("FAIL latency_edge: got %0d expected 3", first);
        end
        n_vec++;
        if (fmt_seen !== 25'd512) begin
            n_err++;
            $display("FAIL latency_fmt: got %0d expected 512", fmt_seen);
        end
    endtask

    task automatic test_a_sweep();
        int n_a;
        logic [31:0] ins;
        n_a = 0;
        for (int p = 0; p < 64; p++) begin
            for (int x = 0; x < 32; x++) begin
                ins = (32'(p) << 26) | (32'd31 << 21) | (32'd31 << 11) | (32'(x) << 1) | 32'(x % 2);
                cycle(1'b1, 1'b0, ins, {$urandom, $urandom});
                n_vec++;
                if (got !== exp_out) begin
                    n_err++;
                    $display("FAIL a_sweep p%0d x%0d: got %h expected %h", p, x, got, exp_out);
                end
                if (got.en === 1'b1 && got.fmt === 25'd512) n_a++;
            end
        end
        repeat (3) begin
            cycle(1'b0, 1'b0, 32'h0, 64'h0);
            n_vec++;
            if (got !== exp_out) begin
                n_err++;
                $display("FAIL a_drain: got %h expected %h", got, exp_out);
            end
            if (got.en === 1'b1 && got.fmt === 25'd512) n_a++;
        end
        n_vec++;
        if (n_a != 24) begin
            n_err++;
            $display("FAIL a_count: got %0d expected 24", n_a);
        end
    endtask

    task automatic test_bd_sweep();
        int nb, nd;
        nb = 0; nd = 0;
        for (int p = 0; p < 67; p++) begin
            cycle(p < 64, 1'b0, (32'(p) << 26) | (32'($urandom) & 32'h03FF_FFFF), {$urandom, $urandom});
            n_vec++;
            if (got !== exp_out) begin
                n_err++;
                $display("FAIL bd_sweep p%0d: got %h expected %h", p, got, exp_out);
            end
            if (got.en === 1'b1 && got.fmt === 25'd2) nb++;
            if (got.en === 1'b1 && got.fmt === 25'd32) nd++;
        end
        n_vec++;
        if (nb != 1) begin
            n_err++;
            $display("FAIL b_count: got %0d expected 1", nb);
        end
        n_vec++;
        if (nd != 40) begin
            n_err++;
            $display("FAIL d_count: got %0d expected 40", nd);
        end
    endtask

    task automatic test_dimm();
        cycle(1'b1, 1'b0, {6'd14, 5'd3, 5'd4, 16'hFFFF}, 64'd1);
        cycle(1'b1, 1'b0, {6'd24, 5'd5, 5'd6, 16'hFFFF}, 64'd2);
        cycle(1'b0, 1'b0, 32'h0, 64'h0);
        n_vec++;
        if (got.body[63:0] !== 64'hFFFF_FFFF_FFFF_FFFF || got !== exp_out) begin
            n_err++;
            $display("FAIL addi_imm: got %h expected ffffffffffffffff", got.body[63:0]);
        end
        cycle(1'b0, 1'b0, 32'h0, 64'h0);
        n_vec++;
        if (got.body[63:0] !== 64'h0000_0000_0000_FFFF || got !== exp_out) begin
            n_err++;
            $display("FAIL ori_imm: got %h expected 000000000000ffff", got.body[63:0]);
        end
        cycle(1'b0, 1'b0, 32'h0, 64'h0);
    endtask

    task automatic test_stall();
        logic [63:0] seen[$];
        logic st;
        logic [31:0] ins;
        int m;
        m = 1;
        for (int c = 1; c <= 11; c++) begin
            st  = (c == 4 || c == 5);
            ins = {6'd14, 10'($urandom), 16'($urandom)};
            if (st)          cycle(1'b1, 1'b1, ins, 64'd99);
            else if (c <= 8) begin cycle(1'b1, 1'b0, ins, 64'(m)); m++; end
            else             cycle(1'b0, 1'b0, ins, 64'd0);
            n_vec++;
            if (got !== exp_out) begin
                n_err++;
                $display("FAIL stall_c%0d: got %h expected %h", c, got, exp_out);
            end
            if (st) begin
                n_vec++;
                if (got.en !== 1'b1 || got.maj !== 64'd1) begin
                    n_err++;
                    $display("FAIL stall_frozen_c%0d: got en=%0b maj=%0d expected en=1 maj=1",
                             c, got.en, got.maj);
                end
            end else if (got.en === 1'b1) begin
                seen.push_back(got.maj);
            end
        end
        n_vec++;
        if (seen.size() != 6) begin
            n_err++;
            $display("FAIL stall_count: got %0d expected 6", seen.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (seen[i] !== 64'(i + 1)) begin
                    n_err++;
                    $display("FAIL stall_order%0d: got %0d expected %0d", i, seen[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int c = 1; c <= 3; c++) begin
            cycle(1'b1, 1'b0, {6'd12, 10'($urandom), 16'($urandom)}, 64'(c));
            n_vec++;
            if (got !== exp_out) begin
                n_err++;
                $display("FAIL prereset_c%0d: got %h expected %h", c, got, exp_out);
            end
        end
        n_vec++;
        if (got.en !== 1'b1) begin
            n_err++;
            $display("FAIL prereset_valid: got %0b expected 1", got.en);
        end
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        n_vec++;
        if (got !== '0) begin
            n_err++;
            $display("FAIL async_clear: got %h expected 0", got);
        end
        h1 = '0; h2 = '0; exp_out = '0;
        repeat (2) begin
            @(posedge clk); #1;
            n_vec++;
            if (got !== '0) begin
                n_err++;
                $display("FAIL reset_held: got %h expected 0", got);
            end
        end
        @(negedge clk);
        reset_i = 1'b1; enable_i = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            cycle(c == 5, 1'b0, {6'd14, 10'($urandom), 16'($urandom)}, 64'd4);
            n_vec++;
            if (got !== exp_out) begin
                n_err++;
                $display("FAIL postreset_c%0d: got %h expected %h", c, got, exp_out);
            end
            if (c == 7) begin
                n_vec++;
                if (got.en !== 1'b1 || got.maj !== 64'd4) begin
                    n_err++;
                    $display("FAIL postreset_first: got en=%0b maj=%0d expected en=1 maj=4",
                             got.en, got.maj);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, rand_instr(),
                  {$urandom, $urandom});
            n_vec++;
            if (got !== exp_out) begin
                n_err++;
                $display("FAIL random_c%0d: got %h expected %h", c, got, exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_a_sweep();
        test_bd_sweep();
        test_dimm();
        test_stall();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
